// File: rtl/dmem_dump_reader_pkg.sv
// Shared data-memory geometry and dump-engine FSM encodings.
package dmem_dump_reader_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_DEPTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_HOLD = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_reader_if.sv
// Control, data-memory read port and byte-stream signals of the dump engine.
// master = dump engine, slave = CPU/memory/consumer side.
interface dmem_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              Start;
  logic [ADDR_W-1:0] Start_Addr;
  logic [ADDR_W:0]   Count;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;
  logic [DATA_W-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic              Out_Last;

  modport master (
    input  Start, Start_Addr, Count, Mem_Data, Out_Ready,
    output Busy, Done, Mem_Addr, Out_Data, Out_Valid, Out_Last
  );

  modport slave (
    output Start, Start_Addr, Count, Mem_Data, Out_Ready,
    input  Busy, Done, Mem_Addr, Out_Data, Out_Valid, Out_Last
  );
endinterface

// File: rtl/dmem_dump_reader_checksum.sv
// Mod-2^W byte accumulator for the dump checksum; clear has priority over add.
module dump_checksum #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] add_dat,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_dat;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/dmem_dump_reader.sv
// Walks a wrapping data-memory range and streams bytes over valid/ready, one byte per 2 cycles.
// First byte valid two edges after Start is driven; DUMP_CHECKSUM_EN appends a two's-complement checksum byte.
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  dmem_dump_reader_if.master  bus
);

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              handshake;

  assign handshake = out_valid_q && bus.Out_Ready;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_sum;

  // Bytes are accumulated as they are captured, so the sum is complete by the last HOLD.
  dump_checksum #(.W(DATA_W)) u_csum (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (state_q == ST_IDLE && bus.Start),
    .add_en  (state_q == ST_READ),
    .add_dat (bus.Mem_Data),
    .sum     (csum_sum)
  );
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.Count != '0) begin
            state_d = ST_READ;
            addr_d  = bus.Start_Addr;
            rem_d   = bus.Count;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d     = ST_HOLD;
        out_data_d  = bus.Mem_Data;
        out_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (rem_q == REM_ONE);
`endif
      end
      ST_HOLD: begin
        if (handshake) begin
          if (rem_q != REM_ONE) begin
            state_d     = ST_READ;
            rem_d       = rem_q - 1'b1;
            addr_d      = addr_q + 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // Valid stays high straight into the checksum byte.
            state_d    = ST_CSUM;
            out_data_d = ~csum_sum + 1'b1;
            out_last_d = 1'b1;
`else
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (handshake) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.Mem_Addr  = addr_q;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Last  = out_last_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = busy_q;

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Read-side engine for the CPU's 32×8 data memory. On a start pulse it walks a contiguous, wrapping address range of the data memory and streams each byte out over a valid/ready byte interface. It is used for debug dumps and for bulk transfer to a host link. It sits beside the CPU on the data-memory read port: it drives the address, samples the asynchronous read data and never writes.

## Interface
Parameters:
- ADDR_W, 5, data-memory address width (32 locations)
- DATA_W, 8, data-memory word width

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- Start_Addr  in  ADDR_W  first address to read
- Count  in  ADDR_W+1  number of bytes, 0..32; 0 means no-op
- Busy  out  1  high in every state except IDLE
- Mem_Addr  out  ADDR_W  address to the data-memory read port (registered)
- Mem_Data  in  DATA_W  combinational read data for Mem_Addr
- Out_Data  out  DATA_W  streamed byte
- Out_Valid  out  1  Out_Data is valid
- Out_Ready  in  1  consumer accepts the byte
- Out_Last  out  1  marks the final byte of the dump; qualified by Out_Valid
- Done  out  1  one-cycle pulse when the dump finishes

## Operation
- FSM states:
  - IDLE → READ when Start is high and Count ≠ 0; latch addr = Start_Addr and rem = Count.
  - IDLE → DONE when Start is high and Count = 0.
  - READ → HOLD. In READ, Mem_Addr = addr; on the clock edge, capture Out_Data = Mem_Data and set Out_Valid = 1.
  - HOLD has Out_Valid = 1, and Out_Data and Out_Last are held stable until Out_Ready = 1.
    - On handshake with rem > 1: rem = rem − 1, addr = (addr + 1) mod 32, clear Out_Valid, go to READ.
    - On handshake with rem = 1: go to CSUM if DUMP_CHECKSUM_EN is defined, else to DONE.
  - CSUM (macro only) presents the checksum byte with Out_Valid = 1 and Out_Last = 1. On handshake → DONE.
  - DONE has Done = 1 for one cycle, then → IDLE.
- Address wraps 31 → 0. Count = 32 reads every location exactly once.
- Start while Busy is ignored. Start_Addr and Count are not re-sampled mid-dump.
- Out_Last = 1 when rem = 1 and the checksum feature is absent.
- Out_Valid never drops without a handshake, except on Reset.
- Mem_Addr always equals the addr register. It holds its value in IDLE, DONE and HOLD.

## Timing
- Reset values: state = IDLE, Busy = 0, Mem_Addr = 0, Out_Data = 0x00, Out_Valid = 0, Out_Last = 0, Done = 0.
- Reset is asynchronous. Asserting it mid-dump clears Out_Valid and Busy immediately; no partial resume.
- Latency: Start at edge N → Out_Valid high after edge N+2.
- Throughput with Out_Ready held high: one byte per 2 cycles.
- Done asserts the cycle after the final handshake.
- Start with Count = 0: Done asserts after edge N+1 and no byte is output.
- Memory contents are sampled in the READ cycle. Writes to the memory after that cycle do not affect the held byte.

## Configuration
- DUMP_CHECKSUM_EN:
  - Defined: an 8-bit accumulator sums all streamed data bytes mod 256, cleared on leaving IDLE. After the last data byte, one extra byte equal to (−sum) mod 256 is sent, so the data bytes plus the checksum sum to 0x00. Out_Last is on the checksum byte only. Count = 0 sends no checksum.
  - Undefined: no CSUM state and no accumulator. Out_Last is on the last data byte.

## Structure
- Shared package/include cpu8_defs holds:
  - DMEM_ADDR_W = 5, DMEM_DATA_W = 8, DMEM_DEPTH = 32
  - FSM state encodings: IDLE, READ, HOLD, CSUM, DONE
- One sub-module is natural: dump_checksum, an 8-bit accumulator with clear and add-enable, instantiated only under DUMP_CHECKSUM_EN.

## Test plan
- Memory preloaded with mem[i] = i+0x10. Start_Addr = 3, Count = 4, Out_Ready = 1 → bytes 0x13, 0x14, 0x15, 0x16, Out_Last on 0x16, one Done pulse, Busy low afterwards.
- Wrap: Start_Addr = 30, Count = 4 → addresses 30, 31, 0, 1; bytes 0x2E, 0x2F, 0x10, 0x11.
- Backpressure: Out_Ready low for 5 cycles in HOLD → Out_Data, Out_Valid and Out_Last stable, Mem_Addr unchanged. The same Count = 4 dump completes with no byte lost or duplicated.
- Count = 0 → no Out_Valid, Done one cycle after Start. Count = 32 from address 7 → all 32 bytes in order 7..31, 0..6.
- Reset low while in HOLD on the 2nd byte → Out_Valid and Busy drop asynchronously. A new Start after release begins cleanly from the new Start_Addr. A Start pulse during Busy has no effect.
- With DUMP_CHECKSUM_EN: bytes 0x01, 0x02, 0x03 → checksum 0xFA follows with Out_Last. All-0x80 bytes with Count = 2 → checksum 0x00.
